// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dm_arbiter
//  Description : Two-port (A = CPU, B = DMA) round-robin arbiter in front of a
//                single-port byte-addressed data memory. One access in flight
//                at most. Every access is range/encoding checked when it is
//                latched, and rejected accesses never touch memory.
//  Ports       : clk, rstn (sync, active-low)
//                a_* / b_*  : req, we, wbits, rbits, addr, wdata in;
//                             gnt, done, err, rdata out
//                mem_*      : r, wr, wbits, rbits, addr, wdata out; rdata in
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_arbiter #(
    parameter int DEPTH   = 512,
    parameter int RR_INIT = 0
) (
    input  logic        clk,
    input  logic        rstn,
    // requester A (CPU)
    input  logic        a_req,
    input  logic        a_we,
    input  logic [1:0]  a_wbits,
    input  logic [2:0]  a_rbits,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_done,
    output logic        a_err,
    output logic [31:0] a_rdata,
    // requester B (DMA)
    input  logic        b_req,
    input  logic        b_we,
    input  logic [1:0]  b_wbits,
    input  logic [2:0]  b_rbits,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_done,
    output logic        b_err,
    output logic [31:0] b_rdata,
    // data memory command
    output logic        mem_r,
    output logic        mem_wr,
    output logic [1:0]  mem_wbits,
    output logic [2:0]  mem_rbits,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_ISSUE = 2'd1;
    localparam logic [1:0]  c_ST_DONE  = 2'd2;

    // Load codes shared with the data memory
    localparam logic [2:0]  c_LD_LB  = 3'b000;
    localparam logic [2:0]  c_LD_LH  = 3'b001;
    localparam logic [2:0]  c_LD_LW  = 3'b010;
    localparam logic [2:0]  c_LD_LBU = 3'b100;
    localparam logic [2:0]  c_LD_LHU = 3'b101;

    localparam logic [32:0] c_DEPTH33 = 33'(DEPTH);

    logic [1:0]  r_state;
    logic        r_prio;      // 0 = A has priority, 1 = B
    logic        r_owner;     // port that owns the access in flight
    logic        r_we;
    logic        r_err;
    logic [1:0]  r_wbits;
    logic [2:0]  r_rbits;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata_a;
    logic [31:0] r_rdata_b;

    logic        w_idle;
    logic        w_issue;
    logic        w_done;
    logic        w_sel_b;
    logic        w_we;
    logic [1:0]  w_wbits;
    logic [2:0]  w_rbits;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [2:0]  w_cnt;
    logic        w_bad_code;
    logic [32:0] w_end;
    logic        w_err;

    // Gating with rstn keeps gnt/done quiet during the reset cycle itself.
    assign w_idle  = rstn && (r_state == c_ST_IDLE);
    assign w_issue = rstn && (r_state == c_ST_ISSUE);
    assign w_done  = rstn && (r_state == c_ST_DONE);

    assign a_gnt = w_idle & a_req & (~b_req | ~r_prio);
    assign b_gnt = w_idle & b_req & (~a_req |  r_prio);

    // Command of whichever port wins this cycle
    assign w_sel_b = b_gnt;
    assign w_we    = w_sel_b ? b_we    : a_we;
    assign w_wbits = w_sel_b ? b_wbits : a_wbits;
    assign w_rbits = w_sel_b ? b_rbits : a_rbits;
    assign w_addr  = w_sel_b ? b_addr  : a_addr;
    assign w_wdata = w_sel_b ? b_wdata : a_wdata;

    always_comb begin
        w_cnt      = 3'd4;
        w_bad_code = 1'b0;
        if (w_we) begin
            case (w_wbits)
                2'b00:   w_cnt = 3'd4;
                2'b01:   w_cnt = 3'd2;
                2'b10:   w_cnt = 3'd1;
                default: w_bad_code = 1'b1;
            endcase
        end else begin
            case (w_rbits)
                c_LD_LW:           w_cnt = 3'd4;
                c_LD_LH, c_LD_LHU: w_cnt = 3'd2;
                c_LD_LB, c_LD_LBU: w_cnt = 3'd1;
                default:           w_bad_code = 1'b1;
            endcase
        end
    end

    // 33-bit end address so accesses near 2^32 cannot wrap into range
    assign w_end = {1'b0, w_addr} + {30'd0, w_cnt};
    assign w_err = w_bad_code | (w_end > c_DEPTH33);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= c_ST_IDLE;
            r_prio    <= (RR_INIT != 0);
            r_owner   <= 1'b0;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_wbits   <= 2'b00;
            r_rbits   <= 3'b000;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_rdata_a <= 32'd0;
            r_rdata_b <= 32'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (a_gnt || b_gnt) begin
                        r_state <= c_ST_ISSUE;
                        r_owner <= w_sel_b;
                        r_prio  <= ~w_sel_b;
                        r_we    <= w_we;
                        r_err   <= w_err;
                        r_wbits <= w_wbits;
                        r_rbits <= w_rbits;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                    end
                end
                c_ST_ISSUE: begin
                    // Result lands directly in the owner's rdata register so
                    // the other port keeps its last completed value.
                    if (r_owner) begin
                        r_rdata_b <= (r_we || r_err) ? 32'd0 : mem_rdata;
                    end else begin
                        r_rdata_a <= (r_we || r_err) ? 32'd0 : mem_rdata;
                    end
                    r_state <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Command registers only change on a handshake, so they hold outside ISSUE
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wbits = r_wbits;
    assign mem_rbits = r_rbits;
    assign mem_wr    = w_issue &  r_we & ~r_err;
    assign mem_r     = w_issue & ~r_we & ~r_err;

    assign a_done  = w_done & ~r_owner;
    assign b_done  = w_done &  r_owner;
    assign a_err   = a_done & r_err;
    assign b_err   = b_done & r_err;
    assign a_rdata = r_rdata_a;
    assign b_rdata = r_rdata_b;

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_arbiter
//  Description : Self-checking bench for dm_arbiter: directed vector table,
//                multi-cycle reset / round-robin sequences, then random
//                traffic from both ports against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;

    localparam int DEPTH = 512;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010,
                           LBU = 3'b100, LHU = 3'b101;

    logic        clk, rstn;
    logic        a_req, a_we, b_req, b_we;
    logic [1:0]  a_wbits, b_wbits;
    logic [2:0]  a_rbits, b_rbits;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_done, a_err, b_gnt, b_done, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic        mem_r, mem_wr;
    logic [1:0]  mem_wbits;
    logic [2:0]  mem_rbits;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dm_arbiter #(.DEPTH(DEPTH), .RR_INIT(0)) dut (
        .clk(clk), .rstn(rstn),
        .a_req(a_req), .a_we(a_we), .a_wbits(a_wbits), .a_rbits(a_rbits),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt), .a_done(a_done),
        .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_wbits(b_wbits), .b_rbits(b_rbits),
        .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt), .b_done(b_done),
        .b_err(b_err), .b_rdata(b_rdata),
        .mem_r(mem_r), .mem_wr(mem_wr), .mem_wbits(mem_wbits),
        .mem_rbits(mem_rbits), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- bench-side data memory (the device) ----------------
    logic [7:0]  mem     [DEPTH];
    logic [7:0]  ref_mem [DEPTH];
    logic [7:0]  dv_b    [4];
    logic [31:0] dv_ia;

    function automatic logic [31:0] ext(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [7:0] b2, input logic [7:0] b3,
                                        input logic [2:0] rb);
        case (rb)
            LW:      return {b3, b2, b1, b0};
            LH:      return {{16{b1[7]}}, b1, b0};
            LHU:     return {16'h0, b1, b0};
            LB:      return {{24{b0[7]}}, b0};
            LBU:     return {24'h0, b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic int nbytes(input logic we, input logic [1:0] wb, input logic [2:0] rb);
        if (we) return (wb == 2'b00) ? 4 : (wb == 2'b01) ? 2 : (wb == 2'b10) ? 1 : 0;
        case (rb)
            LW:       return 4;
            LH, LHU:  return 2;
            LB, LBU:  return 1;
            default:  return 0;
        endcase
    endfunction

    always_comb begin
        dv_ia = 32'd0;
        for (int k = 0; k < 4; k++) begin
            dv_ia = mem_addr + 32'(k);
            dv_b[k] = (dv_ia < 32'(DEPTH)) ? mem[dv_ia[8:0]] : 8'h00;
        end
        mem_rdata = ext(dv_b[0], dv_b[1], dv_b[2], dv_b[3], mem_rbits);
    end

    always @(posedge clk) begin
        if (mem_wr) begin
            for (int k = 0; k < nbytes(1'b1, mem_wbits, 3'b000); k++)
                mem[9'(mem_addr + 32'(k))] <= mem_wdata[8*k +: 8];
        end
    end

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            mem[k]     = 8'h00;
            ref_mem[k] = 8'h00;
        end
    end

    // ---------------- reference model helpers ----------------
    function automatic bit ref_err(input logic we, input logic [1:0] wb,
                                   input logic [2:0] rb, input logic [31:0] ad);
        int n;
        n = nbytes(we, wb, rb);
        return (n == 0) || (longint'(ad) + longint'(n) > longint'(DEPTH));
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] ad, input logic [2:0] rb);
        logic [7:0] b [4];
        for (int k = 0; k < 4; k++)
            b[k] = (ad + 32'(k) < 32'(DEPTH)) ? ref_mem[9'(ad + 32'(k))] : 8'h00;
        return ext(b[0], b[1], b[2], b[3], rb);
    endfunction

    task automatic ref_store(input logic [31:0] ad, input logic [1:0] wb, input logic [31:0] wd);
        for (int k = 0; k < nbytes(1'b1, wb, 3'b000); k++)
            ref_mem[9'(ad + 32'(k))] = wd[8*k +: 8];
    endtask

    // ---------------- checking infrastructure ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle_inputs();
        a_req = 0; a_we = 0; a_wbits = 0; a_rbits = LW; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_wbits = 0; b_rbits = LW; b_addr = 0; b_wdata = 0;
    endtask

    task automatic do_reset();
        step(); rstn = 0; idle_inputs(); #1;
        step(); a_req = 1; #1;
        chk("rst_gnt_forced", 32'({a_gnt, b_gnt}), 32'(0));
        step(); rstn = 1; a_req = 0; #1;
        chk("rst_mem_addr",  mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_bits",  32'({mem_wbits, mem_rbits}), 32'(0));
        chk("rst_rdata_a",   a_rdata, 32'h0);
        chk("rst_rdata_b",   b_rdata, 32'h0);
        chk("rst_ctl",       32'({mem_r, mem_wr, a_done, b_done, a_err, b_err}), 32'(0));
    endtask

    task automatic drive(input bit p, input logic we, input logic [1:0] wb,
                         input logic [2:0] rb, input logic [31:0] ad, input logic [31:0] wd);
        if (p) begin b_req = 1; b_we = we; b_wbits = wb; b_rbits = rb; b_addr = ad; b_wdata = wd; end
        else   begin a_req = 1; a_we = we; a_wbits = wb; a_rbits = rb; a_addr = ad; a_wdata = wd; end
    endtask

    // One isolated access on port p, checked at grant, ISSUE and DONE.
    task automatic access(input bit p, input logic we, input logic [1:0] wb,
                          input logic [2:0] rb, input logic [31:0] ad, input logic [31:0] wd,
                          input bit e_err, input logic [31:0] e_rd, input string nm);
        int  n;
        bit  g;
        step(); drive(p, we, wb, rb, ad, wd); #1;
        n = 0;
        g = p ? b_gnt : a_gnt;
        while (!g && n < 8) begin
            step(); #1; n++;
            g = p ? b_gnt : a_gnt;
        end
        chk({nm, "_gnt"}, 32'(g), 32'(1));
        if (we && !e_err) ref_store(ad, wb, wd);
        step(); a_req = 0; b_req = 0; #1;
        chk({nm, "_mem_r"},  32'(mem_r),  32'(!we && !e_err));
        chk({nm, "_mem_wr"}, 32'(mem_wr), 32'(we && !e_err));
        chk({nm, "_mem_addr"}, mem_addr, ad);
        step(); #1;
        chk({nm, "_done"},  32'(p ? {b_done, a_done} : {a_done, b_done}), 32'(2));
        chk({nm, "_err"},   32'(p ? b_err : a_err), 32'(e_err));
        chk({nm, "_rdata"}, p ? b_rdata : a_rdata, e_rd);
    endtask

    typedef struct {
        bit          p;
        bit          we;
        logic [1:0]  wb;
        logic [2:0]  rb;
        logic [31:0] ad;
        logic [31:0] wd;
        bit          err;
        logic [31:0] rd;
        string       nm;
    } vec_t;

    vec_t tbl[18];

    // ---------------- random-phase model state ----------------
    bit          pend  [2];
    logic        q_we  [2];
    logic [1:0]  q_wb  [2];
    logic [2:0]  q_rb  [2];
    logic [31:0] q_ad  [2];
    logic [31:0] q_wd  [2];
    logic [31:0] last_rd [2];

    initial begin
        int          k, last, guard, w, next_free, r;
        bit          prio, sb_v, sb_p, sb_err, sb_ld, sb_st, ed_a, ed_b;
        int          sb_hs;
        logic [31:0] sb_rd, sb_ad;

        rstn = 0;
        idle_inputs();

        tbl[0]  = '{0, 1, 2'b00, LW,    32'h10,       32'hDEADBEEF, 0, 32'h0,        "sw_deadbeef"};
        tbl[1]  = '{0, 0, 2'b00, LW,    32'h10,       32'h0,        0, 32'hDEADBEEF, "lw_deadbeef"};
        tbl[2]  = '{0, 1, 2'b00, LW,    32'h10,       32'h80000000, 0, 32'h0,        "sw_80000000"};
        tbl[3]  = '{1, 0, 2'b00, LB,    32'h13,       32'h0,        0, 32'hFFFFFF80, "b_lb_13"};
        tbl[4]  = '{1, 0, 2'b00, LBU,   32'h13,       32'h0,        0, 32'h00000080, "b_lbu_13"};
        tbl[5]  = '{0, 0, 2'b00, LH,    32'h12,       32'h0,        0, 32'hFFFF8000, "lh_12"};
        tbl[6]  = '{1, 0, 2'b00, LHU,   32'h12,       32'h0,        0, 32'h00008000, "b_lhu_12"};
        tbl[7]  = '{0, 0, 2'b00, LW,    32'h1FE,      32'h0,        1, 32'h0,        "lw_1fe_err"};
        tbl[8]  = '{0, 1, 2'b10, LW,    32'h1FF,      32'h0000005A, 0, 32'h0,        "sb_1ff"};
        tbl[9]  = '{0, 0, 2'b00, LBU,   32'h1FF,      32'h0,        0, 32'h0000005A, "lbu_1ff"};
        tbl[10] = '{0, 1, 2'b00, LW,    32'h1FC,      32'h11223344, 0, 32'h0,        "sw_1fc"};
        tbl[11] = '{1, 0, 2'b00, LW,    32'h1FC,      32'h0,        0, 32'h11223344, "b_lw_1fc"};
        tbl[12] = '{0, 1, 2'b01, LW,    32'h1FF,      32'h0000FFFF, 1, 32'h0,        "sh_1ff_err"};
        tbl[13] = '{0, 1, 2'b11, LW,    32'h0,        32'h12345678, 1, 32'h0,        "sw_wbits11_err"};
        tbl[14] = '{1, 0, 2'b00, 3'b011, 32'h0,       32'h0,        1, 32'h0,        "b_bad_rbits_err"};
        tbl[15] = '{0, 0, 2'b00, LW,    32'hFFFFFFFC, 32'h0,        1, 32'h0,        "lw_wrap_err"};
        tbl[16] = '{1, 1, 2'b01, LW,    32'h20,       32'h0000ABCD, 0, 32'h0,        "b_sh_20"};
        tbl[17] = '{0, 0, 2'b00, LH,    32'h20,       32'h0,        0, 32'hFFFFABCD, "lh_20"};

        do_reset();

        for (int i = 0; i < 18; i++)
            access(tbl[i].p, tbl[i].we, tbl[i].wb, tbl[i].rb, tbl[i].ad, tbl[i].wd,
                   tbl[i].err, tbl[i].rd, tbl[i].nm);

        // Both ports held: grants alternate A, B, A, B three cycles apart
        do_reset();
        step(); drive(0, 0, 2'b00, LW, 32'h0, 32'h0); drive(1, 0, 2'b00, LW, 32'h4, 32'h0); #1;
        k = 0; last = 0; guard = 0;
        while (k < 4 && guard < 30) begin
            if (a_gnt || b_gnt) begin
                chk("rr_port",   32'(b_gnt), 32'(k % 2));
                chk("rr_single", 32'(a_gnt & b_gnt), 32'(0));
                if (k > 0) chk("rr_gap", 32'(cyc - last), 32'(3));
                last = cyc;
                k++;
            end
            if (k < 4) begin step(); #1; end
            guard++;
        end
        chk("rr_count", 32'(k), 32'(4));
        step(); a_req = 0; b_req = 0; #1;
        step(); #1;

        // Reset during ISSUE of a B load: no done, A wins right after reset
        step(); idle_inputs(); drive(1, 0, 2'b00, LB, 32'h13, 32'h0); #1;
        chk("rstb_gnt", 32'(b_gnt), 32'(1));
        step(); b_req = 0; rstn = 0; #1;
        chk("rstb_done_low", 32'(b_done), 32'(0));
        step(); rstn = 1; drive(0, 0, 2'b00, LW, 32'h10, 32'h0); #1;
        chk("rstb_no_done", 32'({a_done, b_done}), 32'(0));
        chk("rstb_a_gnt",   32'({a_gnt, b_gnt}), 32'(2));
        step(); a_req = 0; #1;
        step(); #1;
        chk("rstb_a_done",  32'({a_done, b_done}), 32'(2));
        chk("rstb_a_rdata", a_rdata, ref_load(32'h10, LW));
        chk("rstb_b_rdata", b_rdata, 32'h0);

        // Reset during ISSUE of an A load: priority returns to A, not B
        step(); idle_inputs(); drive(0, 0, 2'b00, LW, 32'h10, 32'h0); #1;
        chk("rsta_gnt", 32'(a_gnt), 32'(1));
        step(); a_req = 0; rstn = 0; #1;
        step(); rstn = 1; drive(0, 0, 2'b00, LW, 32'h10, 32'h0);
        drive(1, 0, 2'b00, LW, 32'h14, 32'h0); #1;
        chk("rsta_prio", 32'({a_gnt, b_gnt, a_done}), 32'(4));
        step(); a_req = 0; b_req = 0; #1;
        step(); #1;
        chk("rsta_done", 32'({a_done, b_done}), 32'(2));

        // ---------------- random traffic against the model ----------------
        do_reset();
        prio = 0; sb_v = 0; next_free = 0;
        sb_p = 0; sb_err = 0; sb_ld = 0; sb_st = 0; sb_hs = 0; sb_rd = 0; sb_ad = 0;
        for (int p = 0; p < 2; p++) begin pend[p] = 0; last_rd[p] = 32'h0; end
        for (int i = 0; i < 3000; i++) begin
            step();
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1;
                    q_we[p] = 1'($urandom_range(0, 1));
                    q_wb[p] = 2'($urandom_range(0, 3));
                    q_rb[p] = 3'($urandom_range(0, 7));
                    q_wd[p] = $urandom;
                    r = $urandom_range(0, 9);
                    if (r == 0)      q_ad[p] = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
                    else if (r == 1) q_ad[p] = 32'(DEPTH - 4 + $urandom_range(0, 3));
                    else             q_ad[p] = 32'($urandom_range(0, DEPTH - 1));
                end
            end
            a_req = pend[0]; a_we = q_we[0]; a_wbits = q_wb[0]; a_rbits = q_rb[0];
            a_addr = q_ad[0]; a_wdata = q_wd[0];
            b_req = pend[1]; b_we = q_we[1]; b_wbits = q_wb[1]; b_rbits = q_rb[1];
            b_addr = q_ad[1]; b_wdata = q_wd[1];
            #1;

            if (sb_v && cyc == sb_hs + 1) begin
                chk("rnd_mem_r",  32'(mem_r),  32'(sb_ld));
                chk("rnd_mem_wr", 32'(mem_wr), 32'(sb_st));
                chk("rnd_mem_addr", mem_addr, sb_ad);
            end else begin
                chk("rnd_mem_quiet", 32'({mem_r, mem_wr}), 32'(0));
            end

            ed_a = sb_v && (cyc == sb_hs + 2) && !sb_p;
            ed_b = sb_v && (cyc == sb_hs + 2) &&  sb_p;
            chk("rnd_done", 32'({a_done, b_done}), 32'({ed_a, ed_b}));
            if (ed_a || ed_b) begin
                chk("rnd_err", 32'(sb_p ? b_err : a_err), 32'(sb_err));
                last_rd[sb_p] = sb_rd;
                sb_v = 0;
            end
            chk("rnd_rdata_a", a_rdata, last_rd[0]);
            chk("rnd_rdata_b", b_rdata, last_rd[1]);

            w = -1;
            if (cyc >= next_free) begin
                if (pend[0] && pend[1]) w = int'(prio);
                else if (pend[0])       w = 0;
                else if (pend[1])       w = 1;
            end
            chk("rnd_gnt", 32'({a_gnt, b_gnt}),
                32'((w == 0) ? 2 : (w == 1) ? 1 : 0));
            if (w >= 0) begin
                sb_v   = 1;
                sb_p   = (w == 1);
                sb_hs  = cyc;
                sb_ad  = q_ad[w];
                sb_err = ref_err(q_we[w], q_wb[w], q_rb[w], q_ad[w]);
                sb_ld  = !q_we[w] && !sb_err;
                sb_st  =  q_we[w] && !sb_err;
                sb_rd  = sb_ld ? ref_load(q_ad[w], q_rb[w]) : 32'h0;
                if (sb_st) ref_store(q_ad[w], q_wb[w], q_wd[w]);
                next_free = cyc + 3;
                prio = (w == 0);
                pend[w] = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
